// File: rtl/fll_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fll_cfg_pkg
//  Description : Shared types and constants for the APB-to-FLL config bridge:
//                FSM state encoding, register index map, STATUS bit positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package fll_cfg_pkg;

  // Bridge FSM states; one FLL transaction walks IDLE->REQ->RELEASE->RESP
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2,
    RESP    = 2'd3
  } state_e;

  // Register index as decoded from PADDR[4:2]
  localparam logic [2:0] FLL_REG0   = 3'd0;
  localparam logic [2:0] FLL_REG1   = 3'd1;
  localparam logic [2:0] FLL_REG2   = 3'd2;
  localparam logic [2:0] FLL_REG3   = 3'd3;
  localparam logic [2:0] STATUS_IDX = 3'd4;

  // STATUS register bit positions
  localparam int LOCK_BIT    = 0;
  localparam int TIMEOUT_BIT = 1;

endpackage
`default_nettype wire

// File: rtl/fll_lock_sync.sv
`default_nettype none
// ============================================================================
//  Module      : fll_lock_sync
//  Description : Generic two-flop synchronizer bringing an asynchronous level
//                into the clk_i domain. Both stages reset to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module fll_lock_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  // Shift the asynchronous input through two stages
  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  // Synchronizer flops; the first stage may go metastable, the second resolves it
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/apb_fll_cfg_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : apb_fll_cfg_bridge
//  Description : APB slave that turns each access to an FLL register into one
//                four-phase req/ack transaction on the FLL configuration port,
//                with per-phase timeout. Also hosts a local STATUS register
//                (synchronized lock flag, sticky timeout flag).
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_fll_cfg_bridge
  import fll_cfg_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  // APB slave
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  // FLL configuration port (initiator side)
  output logic                      fll_req_o,
  output logic                      fll_wrn_o,
  output logic [1:0]                fll_add_o,
  output logic [31:0]               fll_data_o,
  input  logic                      fll_ack_i,
  input  logic [31:0]               fll_r_data_i,
  input  logic                      fll_lock_i
);

  localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrn_q, wrn_d;
  logic [1:0]       add_q, add_d;
  logic [31:0]      data_q, data_d;
  logic [31:0]      prdata_q, prdata_d;
  logic             pslverr_q, pslverr_d;
  logic             timeout_sticky_q, timeout_sticky_d;

  logic             lock_sync;
  logic [2:0]       reg_idx;
  logic [31:0]      status_word;
  logic             apb_access;
  logic             timeout_hit;
  logic             unused_paddr;

  // Only PADDR[4:2] takes part in decoding; the remaining bits are ignored
  assign unused_paddr = ^{PADDR[APB_ADDR_WIDTH-1:5], PADDR[1:0]};

  assign reg_idx     = PADDR[4:2];
  assign apb_access  = PSEL & PENABLE;
  assign timeout_hit = (cnt_q == TMO_LIMIT);

  fll_lock_sync #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (fll_lock_i),
    .q_o    (lock_sync)
  );

  // Assemble the STATUS read value; unused bits read as zero
  always_comb begin
    status_word              = '0;
    status_word[LOCK_BIT]    = lock_sync;
    status_word[TIMEOUT_BIT] = timeout_sticky_q;
  end

  // Next-state, timeout counter and response register update
  always_comb begin
    state_d          = state_q;
    wrn_d            = wrn_q;
    add_d            = add_q;
    data_d           = data_q;
    prdata_d         = prdata_q;
    pslverr_d        = pslverr_q;
    timeout_sticky_d = timeout_sticky_q;

    unique case (state_q)
      IDLE: begin
        if (apb_access) begin
          // Each access starts with a clean response
          prdata_d  = '0;
          pslverr_d = 1'b0;
          case (reg_idx)
            FLL_REG0, FLL_REG1, FLL_REG2, FLL_REG3: begin
              // Command fields are held on the port for the whole handshake
              // and beyond, until the next FLL access overwrites them
              wrn_d   = ~PWRITE;
              add_d   = reg_idx[1:0];
              data_d  = PWDATA;
              state_d = REQ;
            end
            STATUS_IDX: begin
              if (PWRITE) begin
                if (PWDATA[TIMEOUT_BIT]) begin
                  timeout_sticky_d = 1'b0;
                end
              end else begin
                prdata_d = status_word;
              end
              state_d = RESP;
            end
            default: begin
              pslverr_d = 1'b1;
              state_d   = RESP;
            end
          endcase
        end
      end

      REQ: begin
        if (fll_ack_i) begin
          // Writes return zero; read data is only valid while ack is high
          prdata_d = wrn_q ? fll_r_data_i : 32'h0;
          state_d  = RELEASE;
        end else if (timeout_hit) begin
          pslverr_d        = 1'b1;
          timeout_sticky_d = 1'b1;
          state_d          = RELEASE;
        end
      end

      RELEASE: begin
        if (!fll_ack_i) begin
          state_d = RESP;
        end else if (timeout_hit) begin
          pslverr_d        = 1'b1;
          timeout_sticky_d = 1'b1;
          state_d          = RESP;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Counter restarts on every state entry and only runs while waiting
    if ((state_d != state_q) || (state_q == IDLE) || (state_q == RESP)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // State and datapath registers, cleared asynchronously so a pending request drops at once
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      wrn_q            <= 1'b1;
      add_q            <= 2'b00;
      data_q           <= 32'h0;
      prdata_q         <= 32'h0;
      pslverr_q        <= 1'b0;
      timeout_sticky_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      wrn_q            <= wrn_d;
      add_q            <= add_d;
      data_q           <= data_d;
      prdata_q         <= prdata_d;
      pslverr_q        <= pslverr_d;
      timeout_sticky_q <= timeout_sticky_d;
    end
  end

  // Handshake and ready are pure state decodes, so they fall with the async reset
  assign fll_req_o  = (state_q == REQ);
  assign PREADY     = (state_q == RESP);
  assign PRDATA     = prdata_q;
  assign PSLVERR    = pslverr_q;
  assign fll_wrn_o  = wrn_q;
  assign fll_add_o  = add_q;
  assign fll_data_o = data_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_fll_cfg_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_fll_cfg_bridge
//  Description : Self-checking bench for apb_fll_cfg_bridge. A configurable
//                FLL responder answers the handshake; a transaction-level
//                model predicts latency, response and port values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_fll_cfg_bridge;

  localparam int T  = 8;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rstn_i = 1'b0;
  logic [AW-1:0] PADDR = '0;
  logic [31:0]   PWDATA = '0;
  logic          PWRITE = 1'b0;
  logic          PSEL = 1'b0;
  logic          PENABLE = 1'b0;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic          PSLVERR;
  logic          fll_req_o;
  logic          fll_wrn_o;
  logic [1:0]    fll_add_o;
  logic [31:0]   fll_data_o;
  logic          fll_ack_i;
  logic [31:0]   fll_r_data_i;
  logic          fll_lock_i = 1'b0;

  int checks = 0;
  int errors = 0;

  apb_fll_cfg_bridge #(
    .APB_ADDR_WIDTH (AW),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk_i        (clk),
    .rstn_i       (rstn_i),
    .PADDR        (PADDR),
    .PWDATA       (PWDATA),
    .PWRITE       (PWRITE),
    .PSEL         (PSEL),
    .PENABLE      (PENABLE),
    .PRDATA       (PRDATA),
    .PREADY       (PREADY),
    .PSLVERR      (PSLVERR),
    .fll_req_o    (fll_req_o),
    .fll_wrn_o    (fll_wrn_o),
    .fll_add_o    (fll_add_o),
    .fll_data_o   (fll_data_o),
    .fll_ack_i    (fll_ack_i),
    .fll_r_data_i (fll_r_data_i),
    .fll_lock_i   (fll_lock_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- FLL responder ----------------
  // Ack rises after r_ack_lat cycles of req, and stays high r_rel_lat cycles after req falls
  int          r_ack_lat = 0;
  int          r_rel_lat = 0;
  logic [31:0] r_rdata = 32'h0;
  int          hi_cnt;
  int          lo_cnt;
  logic        acked;

  assign fll_ack_i    = fll_req_o ? (hi_cnt >= r_ack_lat) : (acked && (lo_cnt < r_rel_lat));
  assign fll_r_data_i = r_rdata;

  always @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      hi_cnt <= 0;
      lo_cnt <= 0;
      acked  <= 1'b0;
    end else if (fll_req_o) begin
      hi_cnt <= hi_cnt + 1;
      lo_cnt <= 0;
      if (fll_ack_i) acked <= 1'b1;
    end else begin
      hi_cnt <= 0;
      lo_cnt <= lo_cnt + 1;
      if (!fll_ack_i) acked <= 1'b0;
    end
  end

  // ---------------- transaction-level model ----------------
  int          exp_lat = 0;
  int          exp_hi = 0;
  logic        exp_fll = 1'b0;
  logic        exp_err = 1'b0;
  logic        exp_dchk = 1'b0;
  logic [31:0] exp_prdata = 32'h0;
  logic        exp_wrn = 1'b1;
  logic [1:0]  exp_add = 2'b00;
  logic [31:0] exp_data = 32'h0;
  logic        m_sticky = 1'b0;
  logic        lock_m = 1'b0;

  task automatic set_exp(input logic [AW-1:0] addr, input logic wr, input logic [31:0] wdata,
                         input int alat, input int rlat, input logic [31:0] rdata);
    int idx;
    bit ok;
    idx      = int'(addr[4:2]);
    exp_dchk = 1'b1;
    exp_fll  = 1'b0;
    exp_hi   = 0;
    if (idx < 4) begin
      ok         = (alat <= T);
      exp_fll    = 1'b1;
      exp_wrn    = ~wr;
      exp_add    = addr[3:2];
      exp_data   = wdata;
      exp_hi     = ok ? alat + 1 : T + 1;
      exp_lat    = exp_hi + (ok ? ((rlat <= T) ? rlat + 1 : T + 1) : 1) + 1;
      exp_err    = !ok || (rlat > T);
      exp_prdata = (!wr && ok) ? rdata : 32'h0;
    end else if (idx == 4) begin
      exp_lat    = 1;
      exp_err    = 1'b0;
      exp_prdata = wr ? 32'h0 : {30'h0, m_sticky, lock_m};
      exp_dchk   = !wr;
    end else begin
      exp_lat    = 1;
      exp_err    = 1'b1;
      exp_prdata = 32'h0;
    end
  endtask

  // ---------------- per-cycle compare ----------------
  logic        in_acc = 1'b0;
  int          cyc = 0;
  logic        m_wrn = 1'b1;
  logic [1:0]  m_add = 2'b00;
  logic [31:0] m_data = 32'h0;

  initial begin
    logic exp_rdy;
    logic exp_req;
    forever begin
      @(negedge clk);
      if (!rstn_i) begin
        in_acc = 1'b0;
        m_wrn  = 1'b1;
        m_add  = 2'b00;
        m_data = 32'h0;
      end else if (PSEL && PENABLE) begin
        cyc    = in_acc ? cyc + 1 : 0;
        in_acc = 1'b1;
      end else begin
        in_acc = 1'b0;
      end
      if (in_acc && exp_fll && cyc == 1) begin
        m_wrn  = exp_wrn;
        m_add  = exp_add;
        m_data = exp_data;
      end
      exp_rdy = in_acc && (cyc == exp_lat);
      exp_req = in_acc && exp_fll && (cyc >= 1) && (cyc <= exp_hi);
      chk("pready", PREADY, exp_rdy);
      chk("fll_req", fll_req_o, exp_req);
      chk("fll_wrn", fll_wrn_o, m_wrn);
      chk("fll_add", fll_add_o, m_add);
      chk("fll_data", fll_data_o, m_data);
      if (exp_rdy) begin
        chk("pslverr", PSLVERR, exp_err);
        if (exp_dchk) chk("prdata", PRDATA, exp_prdata);
      end
    end
  end

  // ---------------- APB driver ----------------
  task automatic xfer(input logic [AW-1:0] addr, input logic wr, input logic [31:0] wdata,
                      input int alat, input int rlat, input logic [31:0] rdata,
                      output int lat, output logic [31:0] rd, output logic err);
    @(posedge clk); #1;
    r_ack_lat = alat;
    r_rel_lat = rlat;
    r_rdata   = rdata;
    set_exp(addr, wr, wdata, alat, rlat, rdata);
    PADDR   = addr;
    PWRITE  = wr;
    PWDATA  = wdata;
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    lat = 0;
    forever begin
      @(negedge clk); #2;
      if (PREADY) break;
      lat++;
      if (lat > 2 * T + 10) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout actual=no_pready required=pready addr=0x%03h", addr);
        break;
      end
    end
    rd  = PRDATA;
    err = PSLVERR;
    @(posedge clk); #1;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    if (exp_fll && exp_err) m_sticky = 1'b1;
    else if (addr[4:2] == 3'd4 && wr && wdata[1]) m_sticky = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        err;
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    chk("rst_pready", PREADY, 1'b0);
    chk("rst_pslverr", PSLVERR, 1'b0);
    chk("rst_prdata", PRDATA, 32'h0);
    chk("rst_req", fll_req_o, 1'b0);
    chk("rst_wrn", fll_wrn_o, 1'b1);
    chk("rst_add", fll_add_o, 2'b00);
    chk("rst_data", fll_data_o, 32'h0);
    @(posedge clk); #1;
    rstn_i = 1'b1;

    // Write with combinational ack
    xfer(12'h004, 1'b1, 32'h8000_1234, 0, 0, 32'hDEAD_BEEF, lat, rd, err);
    chk("wr_lat", lat, 3);
    chk("wr_err", err, 1'b0);
    chk("wr_rdata", rd, 32'h0);

    // Read with 3-cycle ack latency
    xfer(12'h00C, 1'b0, 32'h0, 3, 0, 32'hCAFE_0001, lat, rd, err);
    chk("rd_lat", lat, 6);
    chk("rd_data", rd, 32'hCAFE_0001);
    chk("rd_err", err, 1'b0);

    // Responder never acks: REQ times out after T+1 cycles
    xfer(12'h000, 1'b1, 32'h1111_2222, 1000, 0, 32'h0, lat, rd, err);
    chk("to_lat", lat, T + 3);
    chk("to_err", err, 1'b1);
    xfer(12'h010, 1'b0, 32'h0, 0, 0, 32'h0, lat, rd, err);
    chk("status_sticky", rd, 32'h2);
    xfer(12'h010, 1'b1, 32'h2, 0, 0, 32'h0, lat, rd, err);
    xfer(12'h010, 1'b0, 32'h0, 0, 0, 32'h0, lat, rd, err);
    chk("status_clr", rd, 32'h0);

    // Lock becomes visible after two cycles
    @(posedge clk); #1;
    fll_lock_i = 1'b1;
    lock_m     = 1'b1;
    xfer(12'h010, 1'b0, 32'h0, 0, 0, 32'h0, lat, rd, err);
    chk("status_lock", rd, 32'h1);

    // Illegal address
    xfer(12'h014, 1'b0, 32'h0, 0, 0, 32'h5555_AAAA, lat, rd, err);
    chk("ill_lat", lat, 1);
    chk("ill_err", err, 1'b1);
    chk("ill_data", rd, 32'h0);

    // Ack held high past the RELEASE timeout
    xfer(12'h008, 1'b0, 32'h0, 0, 1000, 32'h1234_5678, lat, rd, err);
    chk("rel_to_lat", lat, T + 3);
    chk("rel_to_err", err, 1'b1);

    // Reset while in REQ
    @(posedge clk); #1;
    r_ack_lat = 1000;
    r_rel_lat = 0;
    set_exp(12'h004, 1'b1, 32'hAAAA_0000, 1000, 0, 32'h0);
    PADDR = 12'h004; PWRITE = 1'b1; PWDATA = 32'hAAAA_0000; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    chk("pre_rst_req", fll_req_o, 1'b1);
    rstn_i = 1'b0;
    #1;
    chk("abort_req", fll_req_o, 1'b0);
    chk("abort_pready", PREADY, 1'b0);
    PSEL = 1'b0; PENABLE = 1'b0;
    m_sticky = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn_i = 1'b1;
    repeat (3) @(posedge clk);
    xfer(12'h00C, 1'b1, 32'h0BAD_F00D, 0, 0, 32'h0, lat, rd, err);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_err", err, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      int sel;
      int alat;
      int rlat;
      logic [AW-1:0] a;
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
        lock_m     = ~lock_m;
        fll_lock_i = lock_m;
        repeat (2) @(posedge clk);
      end
      sel = $urandom_range(0, 9);
      alat = (sel < 5) ? sel : (sel == 5) ? T - 1 : (sel == 6) ? T : (sel == 7) ? T + 1 : (sel == 8) ? 1000 : 2;
      sel = $urandom_range(0, 9);
      rlat = (sel < 6) ? sel : (sel == 6) ? T : (sel == 7) ? T + 1 : 1;
      a = AW'($urandom);
      xfer(a, 1'($urandom), $urandom, alat, rlat, $urandom, lat, rd, err);
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
